// File: rtl/swimmer_sprite_drawer.sv
// Swimmer sprite pixel engine.
// Walks an SPR_W x SPR_H box at the latched swimmer position, one pixel per
// cycle. Each pixel is written to the VGA adapter port from either the sprite
// ROM (draw) or the background ROM (erase). Both ROMs have a 1-cycle read, so
// pixel coordinates pass through a one-stage pipeline to meet the ROM data.
module swimmer_sprite_drawer #(
    parameter int unsigned SPR_W  = 11,
    parameter int unsigned SPR_H  = 17,
    parameter int unsigned SCR_W  = 160,
    parameter int unsigned SCR_H  = 120,
    parameter logic [2:0]  TRANSP = 3'b111,
    parameter int unsigned SPR_AW = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              plot,
    input  logic              earse,
    input  logic [7:0]        swimmerX,
    input  logic [6:0]        swimmerY,
    input  logic [8:0]        bY,
    output logic [SPR_AW-1:0] spr_addr,
    input  logic [2:0]        spr_colour,
    output logic [16:0]       bg_addr,
    input  logic [2:0]        bg_colour,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_writeEn,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PXW = $clog2(SPR_W);
    localparam int unsigned PYW = $clog2(SPR_H);
    localparam logic [PXW-1:0] PX_LAST = PXW'(SPR_W - 1);
    localparam logic [PYW-1:0] PY_LAST = PYW'(SPR_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [PXW-1:0] px_q, px_d;
    logic [PYW-1:0] py_q, py_d;
    logic [1:0]     served_q, served_d;
    logic [7:0]     x0_q, x0_d;
    logic [6:0]     y0_q, y0_d;
    logic [8:0]     b0_q, b0_d;
    logic           mode_q, mode_d;

    logic           p_valid_q, p_valid_d;
    logic [8:0]     p_x_q, p_x_d;
    logic [7:0]     p_y_q, p_y_d;

    logic [1:0]     tag;
    logic           in_run;
    logic [8:0]     pix_x;
    logic [7:0]     pix_y;
    logic [9:0]     bg_row;
    logic [16:0]    bg_lin;

    assign tag    = {plot, earse};
    assign in_run = (state_q == S_RUN);

    // Screen coordinate of the pixel currently being addressed; 9/8 bits wide
    // so positions past the right/bottom edge are visible to the clip test.
    assign pix_x  = {1'b0, x0_q} + 9'(px_q);
    assign pix_y  = {1'b0, y0_q} + 8'(py_q);

    // Background row includes the scroll offset; row pitch of 160 is built as
    // r*128 + r*32, and the sum wraps naturally at 17 bits.
    assign bg_row = {1'b0, b0_q} + 10'(y0_q) + 10'(py_q);
    assign bg_lin = {bg_row, 7'b0} + {2'b0, bg_row, 5'b0} + {8'b0, pix_x};

    assign spr_addr = in_run ? (SPR_AW'(py_q) * SPR_AW'(SPR_W) + SPR_AW'(px_q)) : '0;
    assign bg_addr  = in_run ? bg_lin : '0;

    // Write stage: ROM data arrives alongside the registered coordinates.
    // Off-screen pixels still take their cycle but are never strobed, and the
    // colour key suppresses transparent sprite pixels in draw mode only.
    assign vga_x       = p_x_q[7:0];
    assign vga_y       = p_y_q[6:0];
    assign vga_colour  = mode_q ? bg_colour : spr_colour;
    assign vga_writeEn = p_valid_q
                       & (p_x_q < 9'(SCR_W))
                       & (p_y_q < 8'(SCR_H))
                       & (mode_q | (spr_colour != TRANSP));

    assign busy = (state_q == S_RUN) | (state_q == S_FLUSH);
    assign done = (state_q == S_DONE);

    // Next-state logic: request detection, box walk and pipeline feed.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        served_d  = served_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        b0_d      = b0_q;
        mode_d    = mode_q;
        p_valid_d = in_run;
        p_x_d     = pix_x;
        p_y_d     = pix_y;

        case (state_q)
            S_IDLE: begin
                if (plot && (tag != served_q)) begin
                    state_d  = S_RUN;
                    served_d = tag;
                    x0_d     = swimmerX;
                    y0_d     = swimmerY;
                    b0_d     = bY;
                    mode_d   = earse;
                    px_d     = '0;
                    py_d     = '0;
                end else if (!plot) begin
                    // Forget the last request so the next plot retriggers.
                    served_d = 2'b00;
                end
            end
            S_RUN: begin
                if (px_q == PX_LAST) begin
                    px_d = '0;
                    if (py_q == PY_LAST) begin
                        py_d    = '0;
                        state_d = S_FLUSH;
                    end else begin
                        py_d = py_q + 1'b1;
                    end
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; a reset mid-pass
    // drops the pipeline valid bit so no further writes escape.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!resetn) begin
            state_q   <= S_IDLE;
            px_q      <= '0;
            py_q      <= '0;
            served_q  <= 2'b00;
            x0_q      <= '0;
            y0_q      <= '0;
            b0_q      <= '0;
            mode_q    <= 1'b0;
            p_valid_q <= 1'b0;
            p_x_q     <= '0;
            p_y_q     <= '0;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            served_q  <= served_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            b0_q      <= b0_d;
            mode_q    <= mode_d;
            p_valid_q <= p_valid_d;
            p_x_q     <= p_x_d;
            p_y_q     <= p_y_d;
        end
    end

endmodule

// File: tb/tb_swimmer_sprite_drawer.sv
// Directed bench for swimmer_sprite_drawer. Sprite ROM returns addr[2:0],
// background ROM returns addr[4:2]; both with a one-cycle registered read.
module tb_swimmer_sprite_drawer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        plot;
    logic        earse;
    logic [7:0]  swimmerX;
    logic [6:0]  swimmerY;
    logic [8:0]  bY;
    logic [7:0]  spr_addr;
    logic [2:0]  spr_colour;
    logic [16:0] bg_addr;
    logic [2:0]  bg_colour;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_writeEn;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int k;

    int          wr_cnt   = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic [7:0]  last_x;
    logic [6:0]  last_y;
    logic [2:0]  last_c;

    swimmer_sprite_drawer dut (
        .clock       (clock),
        .resetn      (resetn),
        .plot        (plot),
        .earse       (earse),
        .swimmerX    (swimmerX),
        .swimmerY    (swimmerY),
        .bY          (bY),
        .spr_addr    (spr_addr),
        .spr_colour  (spr_colour),
        .bg_addr     (bg_addr),
        .bg_colour   (bg_colour),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_writeEn (vga_writeEn),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // ROM models with synchronous read.
    always @(posedge clock) begin
        spr_colour <= spr_addr[2:0];
        bg_colour  <= bg_addr[4:2];
    end

    // Write/busy/done observer, sampled mid-cycle.
    always @(negedge clock) begin
        if (vga_writeEn === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            last_x = vga_x;
            last_y = vga_y;
            last_c = vga_colour;
        end
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; plot = 1'b0; earse = 1'b0;
        swimmerX = 8'd80; swimmerY = 7'd80; bY = 9'd0;

        // 1. Reset with plot low: no writes, all outputs zero.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_we", vga_writeEn, 0);
        end
        chk("reset_spr_addr", spr_addr, 0);
        chk("reset_bg_addr", bg_addr, 0);
        chk("reset_vga_x", vga_x, 0);
        chk("reset_vga_y", vga_y, 0);
        chk("reset_colour", vga_colour, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        resetn = 1'b1;
        step(); step();
        chk("idle_busy", busy, 0);

        // 2. Draw pass at (80,80). Addresses 0..186 with low bits 3'b111:
        //    7,15,...,183 = 23 skipped, so 164 writes.
        wr_cnt = 0; busy_cnt = 0;
        plot = 1'b1; earse = 1'b0; k = 0;
        step(); k++;
        chk("draw_busy_t1", busy, 1);
        chk("draw_addr_t1", spr_addr, 0);
        step(); k++;
        chk("draw_we_t2", vga_writeEn, 1);
        chk("draw_x_t2", vga_x, 80);
        chk("draw_y_t2", vga_y, 80);
        chk("draw_addr_t2", spr_addr, 1);
        while (done !== 1'b1 && k < 400) begin step(); k++; end
        chk("draw_done_cycle", k, 189);
        chk("draw_writes", wr_cnt, 164);
        chk("draw_busy_cycles", busy_cnt, 188);
        chk("draw_last_x", last_x, 90);
        chk("draw_last_y", last_y, 96);
        step(); k++;
        chk("draw_done_pulse", done, 0);
        step();
        chk("draw_hold_no_retrig", busy, 0);

        // 3. Erase pass, bY=280: row 360 -> 360*160+80 = 57680, colour 4.
        //    Last pixel: row 376, x 90 -> 60250, colour 6.
        plot = 1'b0; step(); step();
        swimmerX = 8'd80; swimmerY = 7'd80; bY = 9'd280;
        earse = 1'b1; plot = 1'b1; wr_cnt = 0; k = 0;
        step(); k++;
        chk("erase_bg_addr_t1", bg_addr, 57680);
        step(); k++;
        chk("erase_we_t2", vga_writeEn, 1);
        chk("erase_colour_t2", vga_colour, 4);
        while (done !== 1'b1 && k < 400) begin step(); k++; end
        chk("erase_done_cycle", k, 189);
        chk("erase_writes", wr_cnt, 187);
        chk("erase_last_x", last_x, 90);
        chk("erase_last_y", last_y, 96);
        chk("erase_last_colour", last_c, 6);

        // 4. Clipping at (155,110): x 155..159, y 110..119 -> 50 writes.
        plot = 1'b0; step(); step();
        swimmerX = 8'd155; swimmerY = 7'd110; bY = 9'd0;
        earse = 1'b1; plot = 1'b1; wr_cnt = 0; k = 0;
        step(); k++;
        step(); k++;
        chk("clip_we_t2", vga_writeEn, 1);
        chk("clip_x_t2", vga_x, 155);
        while (done !== 1'b1 && k < 400) begin step(); k++; end
        chk("clip_done_cycle", k, 189);
        chk("clip_writes", wr_cnt, 50);
        chk("clip_last_x", last_x, 159);
        chk("clip_last_y", last_y, 119);

        // 5. Tag sequencing: earse rises mid draw; erase follows right after
        //    done (row 80 -> 80*160+80 = 12880, colour 4); then no third pass.
        plot = 1'b0; step(); step();
        swimmerX = 8'd80; swimmerY = 7'd80; bY = 9'd0;
        earse = 1'b0; plot = 1'b1; k = 0;
        step(); k++;
        chk("tag_draw_busy", busy, 1);
        while (k < 20) begin step(); k++; end
        earse = 1'b1;
        while (done !== 1'b1 && k < 400) begin step(); k++; end
        chk("tag_draw_done_cycle", k, 189);
        step(); k++;
        chk("tag_idle_gap", busy, 0);
        step(); k++;
        chk("tag_erase_busy", busy, 1);
        chk("tag_erase_bg_addr", bg_addr, 12880);
        chk("tag_erase_spr_addr", spr_addr, 0);
        step(); k++;
        chk("tag_erase_we", vga_writeEn, 1);
        chk("tag_erase_colour", vga_colour, 4);
        while (done !== 1'b1 && k < 600) begin step(); k++; end
        chk("tag_erase_done_cycle", k, 379);
        step();
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 250; i++) step();
        chk("tag_no_third_busy", busy_cnt, 0);
        chk("tag_no_third_done", done_cnt, 0);

        // 6. Reset at pixel 50 aborts; release with plot high restarts.
        plot = 1'b0; step(); step();
        earse = 1'b0; plot = 1'b1; k = 0;
        while (k < 51) begin step(); k++; end
        chk("rst_addr_px50", spr_addr, 50);
        resetn = 1'b0;
        step();
        done_cnt = 0;
        chk("rst_we", vga_writeEn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step();
        chk("rst_done_hold", done, 0);
        resetn = 1'b1; k = 0;
        step(); k++;
        chk("rst_restart_busy", busy, 1);
        chk("rst_restart_addr", spr_addr, 0);
        step(); k++;
        chk("rst_restart_we", vga_writeEn, 1);
        chk("rst_restart_x", vga_x, 80);
        chk("rst_restart_y", vga_y, 80);
        while (done !== 1'b1 && k < 400) begin step(); k++; end
        chk("rst_restart_done_cycle", k, 189);
        chk("rst_no_aborted_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
